// File: rtl/hslp_pipe_mul.sv
// 3-stage valid/ready W x W unsigned multiplier built from four (W/2)x(W/2) sub-products, each optionally
// truncated per beat via a mode tag. Define HSLP_COMP_EN to add +2^(TRUNC-1) bias to truncated sub-products.
module hslp_pipe_mul #(
  parameter int unsigned W     = 8,
  parameter int unsigned TRUNC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [3:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod,
  output logic [3:0]     out_mode
);
  localparam int unsigned H = W / 2;
  localparam logic [W-1:0] KEEP = {W{1'b1}} << TRUNC;
`ifdef HSLP_COMP_EN
  localparam logic [W-1:0] BIAS = (TRUNC > 0) ? (W'(1) << ((TRUNC > 0) ? TRUNC - 1 : 0)) : '0;
`endif

  function automatic logic [W-1:0] approx(input logic [W-1:0] p, input logic trunc);
`ifdef HSLP_COMP_EN
    return trunc ? ((p & KEEP) | BIAS) : p;
`else
    return trunc ? (p & KEEP) : p;
`endif
  endfunction

  logic           advance;
  logic           v1_q, v2_q, v3_q;
  logic [W-1:0]   a1_q, b1_q;
  logic [3:0]     m1_q, m2_q, m3_q;
  logic [W-1:0]   hh_q, hl_q, lh_q, ll_q;
  logic [W-1:0]   hh_d, hl_d, lh_d, ll_d;
  logic [W:0]     mid_d;
  logic [2*W-1:0] prod_q, prod_d;

  assign advance   = out_ready | ~v3_q;
  assign in_ready  = advance & ~rst;
  assign out_valid = v3_q;
  assign prod      = prod_q;
  assign out_mode  = m3_q;

  always_comb begin
    hh_d = approx(W'(a1_q[W-1:H]) * W'(b1_q[W-1:H]), m1_q[3]);
    hl_d = approx(W'(a1_q[W-1:H]) * W'(b1_q[H-1:0]), m1_q[2]);
    lh_d = approx(W'(a1_q[H-1:0]) * W'(b1_q[W-1:H]), m1_q[1]);
    ll_d = approx(W'(a1_q[H-1:0]) * W'(b1_q[H-1:0]), m1_q[0]);
  end

  // Summed at 2W bits: the carry out of bit 2W-1 is discarded, matching a 2W+1-bit sum truncated to 2W.
  always_comb begin
    mid_d  = (W+1)'(hl_q) + (W+1)'(lh_q);
    prod_d = {hh_q, {W{1'b0}}} + ((2*W)'(mid_d) << H) + (2*W)'(ll_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      m1_q   <= '0;
      m2_q   <= '0;
      m3_q   <= '0;
      hh_q   <= '0;
      hl_q   <= '0;
      lh_q   <= '0;
      ll_q   <= '0;
      prod_q <= '0;
    end else if (advance) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_valid) begin
        a1_q <= a;
        b1_q <= b;
        m1_q <= mode;
      end
      if (v1_q) begin
        hh_q <= hh_d;
        hl_q <= hl_d;
        lh_q <= lh_d;
        ll_q <= ll_d;
        m2_q <= m1_q;
      end
      if (v2_q) begin
        prod_q <= prod_d;
        m3_q   <= m2_q;
      end
    end
  end
endmodule
